// File: rtl/cmd_ingress_buffer_pkg.sv
// Package ddr_cmd_pkg: command word layout for the DDR3 ingress buffer.
//   CMD_W           : width of the host command word
//   *_BIT / *_LSB   : bit positions of each field inside the command word
//   cmd_t           : packed view of the command word (MSB first)
//   cmd_malformed() : true when a reserved bit is set or BL4 is requested
package ddr_cmd_pkg;

  localparam int CMD_W    = 34;
  localparam int BANK_LSB = 0;
  localparam int COL_LSB  = 3;
  localparam int AP_BIT   = 13;
  localparam int RSV0_BIT = 14;
  localparam int BL_BIT   = 15;
  localparam int RSV1_BIT = 16;
  localparam int ROW_LSB  = 17;
  localparam int RSV2_BIT = 30;
  localparam int RW_BIT   = 31;
  localparam int RANK_LSB = 32;

  typedef struct packed {
    logic [1:0]  rank;  // [33:32]
    logic        rw;    // [31]    0 = write, 1 = read
    logic        rsv2;  // [30]
    logic [12:0] row;   // [29:17]
    logic        rsv1;  // [16]
    logic        bl;    // [15]    1 = BL8 (BL4 unsupported)
    logic        rsv0;  // [14]
    logic        ap;    // [13]
    logic [9:0]  col;   // [12:3]
    logic [2:0]  bank;  // [2:0]
  } cmd_t;

  function automatic logic cmd_malformed(input cmd_t c);
    return c.rsv0 | c.rsv1 | c.rsv2 | ~c.bl;
  endfunction

endpackage

// File: rtl/cmd_ingress_buffer_if.sv
// Host-side command interface of cmd_ingress_buffer.
//   in_valid      : host presents a command
//   in_ready      : buffer can accept a command this cycle
//   in_command    : 34-bit command word (layout in ddr_cmd_pkg::cmd_t)
//   in_write_data : DQ_BITS*8 write data, ignored for reads
// Modports: master = host (drives the command), slave = buffer.
interface cmd_ingress_buffer_if
  import ddr_cmd_pkg::*;
#(
  parameter int DQ_BITS = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [CMD_W-1:0]       in_command;
  logic [DQ_BITS*8-1:0]   in_write_data;

  modport master (
    output in_valid,
    output in_command,
    output in_write_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_command,
    input  in_write_data,
    output in_ready
  );
endinterface

// File: rtl/cmd_ingress_buffer_fifo.sv
// cmd_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/push_data : write request, ignored while full
//   pop            : read request, ignored while empty
//   pop_data       : current head entry (valid while !empty)
//   full, empty    : status from registered pointers only, so a pop does not
//                    free a slot for a push in the same cycle
// Pointers carry one extra wrap bit: full when the wrap bits differ and the
// index bits match.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign pop_data = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push && !full) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end
endmodule

// File: rtl/cmd_ingress_buffer.sv
// cmd_ingress_buffer: in-order command queue in front of the DDR3 controller.
// Commands are issued only when the head's bank is ready (ba_cmd_pm) and, for
// reads, the read-in-flight limit MAX_RD is not reached. Malformed commands
// (reserved bit set, or BL4) are dropped with a one-cycle err_malformed pulse.
// Ports:
//   clk, power_on_rst_n : clock, async active-low reset
//   host                : cmd_ingress_buffer_if.slave (in_valid/in_ready/in_command/in_write_data)
//   ba_cmd_pm           : per-bank ready-for-command
//   read_data_valid     : one read burst returned
//   valid/command/write_data : registered issue outputs, zero when idle
//   rd_outstanding      : reads issued but not returned
//   err_malformed       : dropped-command pulse
// Optional: define INGRESS_STATS_EN to add stat_wr_cnt, stat_rd_cnt and
// stat_stall_cnt (saturating 32-bit counters).
module cmd_ingress_buffer
  import ddr_cmd_pkg::*;
#(
  parameter int DQ_BITS = 16,
  parameter int DEPTH   = 8,
  parameter int MAX_RD  = 16,
  localparam int DATA_W = DQ_BITS * 8,
  localparam int RD_W   = $clog2(MAX_RD + 1)
) (
  input  logic                clk,
  input  logic                power_on_rst_n,
  cmd_ingress_buffer_if.slave host,
  input  logic [7:0]          ba_cmd_pm,
  input  logic                read_data_valid,
  output logic                valid,
  output logic [CMD_W-1:0]    command,
  output logic [DATA_W-1:0]   write_data,
  output logic [RD_W-1:0]     rd_outstanding,
  output logic                err_malformed
`ifdef INGRESS_STATS_EN
  ,
  output logic [31:0]         stat_wr_cnt,
  output logic [31:0]         stat_rd_cnt,
  output logic [31:0]         stat_stall_cnt
`endif
);
  localparam int ENTRY_W = CMD_W + DATA_W;

  cmd_t                in_cmd_s;
  logic                accept_s;
  logic                bad_cmd_s;
  logic                push_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [ENTRY_W-1:0]  head_entry_s;
  cmd_t                head_cmd_s;
  logic [DATA_W-1:0]   head_wdata_s;
  logic                issue_s;
  logic                rd_inc_s;
  logic                rd_dec_s;

  logic                valid_r;
  logic [CMD_W-1:0]    command_r;
  logic [DATA_W-1:0]   write_data_r;
  logic [RD_W-1:0]     rd_cnt_r;
  logic                err_r;

  assign in_cmd_s      = cmd_t'(host.in_command);
  assign host.in_ready = !fifo_full_s;
  assign accept_s      = host.in_valid && !fifo_full_s;
  assign bad_cmd_s     = cmd_malformed(in_cmd_s);
  assign push_s        = accept_s && !bad_cmd_s;

  assign head_cmd_s    = cmd_t'(head_entry_s[CMD_W-1:0]);
  assign head_wdata_s  = head_entry_s[ENTRY_W-1:CMD_W];

  cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (power_on_rst_n),
    .push      (push_s),
    .push_data ({host.in_write_data, host.in_command}),
    .pop       (issue_s),
    .pop_data  (head_entry_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Head eligibility: bank ready and, for reads, room under the in-flight limit
  always_comb begin
    issue_s = 1'b0;
    if (fifo_empty_s) begin
      issue_s = 1'b0;
    end else if (!ba_cmd_pm[head_cmd_s.bank]) begin
      issue_s = 1'b0;
    end else if (head_cmd_s.rw && (rd_cnt_r >= RD_W'(MAX_RD))) begin
      issue_s = 1'b0;
    end else begin
      issue_s = 1'b1;
    end
  end

  assign rd_inc_s = issue_s && head_cmd_s.rw;
  // A return with nothing in flight is ignored rather than wrapping the count
  assign rd_dec_s = read_data_valid && (rd_cnt_r != {RD_W{1'b0}});

  // Registered issue outputs, forced to zero on idle cycles
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      valid_r      <= 1'b0;
      command_r    <= {CMD_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
    end else if (issue_s) begin
      valid_r      <= 1'b1;
      command_r    <= head_cmd_s;
      write_data_r <= head_cmd_s.rw ? {DATA_W{1'b0}} : head_wdata_s;
    end else begin
      valid_r      <= 1'b0;
      command_r    <= {CMD_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
    end
  end

  // Reads-in-flight counter; simultaneous issue and return cancel out
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      rd_cnt_r <= {RD_W{1'b0}};
    end else begin
      case ({rd_inc_s, rd_dec_s})
        2'b10:   rd_cnt_r <= rd_cnt_r + RD_W'(1);
        2'b01:   rd_cnt_r <= rd_cnt_r - RD_W'(1);
        default: rd_cnt_r <= rd_cnt_r;
      endcase
    end
  end

  // Malformed-command drop pulse
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= accept_s && bad_cmd_s;
    end
  end

  assign valid          = valid_r;
  assign command        = command_r;
  assign write_data     = write_data_r;
  assign rd_outstanding = rd_cnt_r;
  assign err_malformed  = err_r;

`ifdef INGRESS_STATS_EN
  logic [31:0] stat_wr_r;
  logic [31:0] stat_rd_r;
  logic [31:0] stat_stall_r;

  // Saturating issue and stall statistics
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      stat_wr_r    <= 32'd0;
      stat_rd_r    <= 32'd0;
      stat_stall_r <= 32'd0;
    end else begin
      if (issue_s && !head_cmd_s.rw && (stat_wr_r != 32'hFFFF_FFFF)) begin
        stat_wr_r <= stat_wr_r + 32'd1;
      end
      if (rd_inc_s && (stat_rd_r != 32'hFFFF_FFFF)) begin
        stat_rd_r <= stat_rd_r + 32'd1;
      end
      if (!fifo_empty_s && !issue_s && (stat_stall_r != 32'hFFFF_FFFF)) begin
        stat_stall_r <= stat_stall_r + 32'd1;
      end
    end
  end

  assign stat_wr_cnt    = stat_wr_r;
  assign stat_rd_cnt    = stat_rd_r;
  assign stat_stall_cnt = stat_stall_r;
`endif
endmodule

// File: tb/tb_cmd_ingress_buffer.sv
// Self-checking bench for cmd_ingress_buffer (DQ_BITS=16, DEPTH=8, MAX_RD=2).
// A cycle-level reference model (queue + counter) predicts every issue; issued
// commands go to a scoreboard queue that a negedge monitor pops and compares.
module tb_cmd_ingress_buffer;
  localparam int DQ_BITS = 16;
  localparam int DEPTH   = 8;
  localparam int MAX_RD  = 2;
  localparam int DW      = DQ_BITS * 8;
  localparam int RW      = $clog2(MAX_RD + 1);

  typedef struct {
    logic [33:0]   c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    ba_cmd_pm = 8'h00;
  logic          read_data_valid = 1'b0;
  logic          valid;
  logic [33:0]   command;
  logic [DW-1:0] write_data;
  logic [RW-1:0] rd_outstanding;
  logic          err_malformed;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  ent_t mq[$];
  ent_t exp_q[$];
  int   m_rd    = 0;
  bit   m_valid = 1'b0;
  bit   m_err   = 1'b0;

  cmd_ingress_buffer_if #(.DQ_BITS(DQ_BITS)) host_if ();

`ifdef INGRESS_STATS_EN
  logic [31:0] stat_wr_cnt, stat_rd_cnt, stat_stall_cnt;
`endif

  cmd_ingress_buffer #(
    .DQ_BITS (DQ_BITS),
    .DEPTH   (DEPTH),
    .MAX_RD  (MAX_RD)
  ) dut (
    .clk             (clk),
    .power_on_rst_n  (rst_n),
    .host            (host_if.slave),
    .ba_cmd_pm       (ba_cmd_pm),
    .read_data_valid (read_data_valid),
    .valid           (valid),
    .command         (command),
    .write_data      (write_data),
    .rd_outstanding  (rd_outstanding),
    .err_malformed   (err_malformed)
`ifdef INGRESS_STATS_EN
    ,
    .stat_wr_cnt     (stat_wr_cnt),
    .stat_rd_cnt     (stat_rd_cnt),
    .stat_stall_cnt  (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] mk_cmd(input logic [1:0] rank, input logic rw, input logic [12:0] row,
                                         input logic bl, input logic ap, input logic [9:0] col,
                                         input logic [2:0] bank);
    return {rank, rw, 1'b0, row, 1'b0, bl, 1'b0, ap, col, bank};
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: one step per clock from the rules of the queue
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      m_rd    = 0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      int   size_before;
      bit   elig;
      bit   inc;
      bit   dec;
      logic [33:0] ic;
      ent_t e;
      size_before = mq.size();
      elig = 1'b0;
      if (size_before > 0) begin
        elig = ba_cmd_pm[mq[0].c[2:0]] && (!mq[0].c[31] || m_rd < MAX_RD);
      end
      inc = 1'b0;
      if (elig) begin
        e = mq.pop_front();
        inc = e.c[31];
        if (e.c[31]) e.d = '0;
        exp_q.push_back(e);
      end
      m_valid = elig;
      m_err   = 1'b0;
      ic = host_if.in_command;
      if (host_if.in_valid && size_before < DEPTH) begin
        if (ic[14] || ic[16] || ic[30] || !ic[15]) begin
          m_err = 1'b1;
        end else begin
          e.c = ic;
          e.d = host_if.in_write_data;
          mq.push_back(e);
        end
      end
      dec = read_data_valid && (m_rd > 0);
      m_rd = m_rd + int'(inc) - int'(dec);
    end
  end

  // Monitor: per-cycle status and scoreboard pop on every issue
  always @(negedge clk) begin
    if (rst_n) begin
      ent_t e;
      check("valid", DW'(valid), DW'(m_valid));
      check("err_malformed", DW'(err_malformed), DW'(m_err));
      check("rd_outstanding", DW'(rd_outstanding), DW'(m_rd));
      check("in_ready", DW'(host_if.in_ready), DW'(mq.size() < DEPTH));
      if (valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_issue: got command %0h, expected no issue", command);
        end else begin
          e = exp_q.pop_front();
          check("command", DW'(command), DW'(e.c));
          check("write_data", write_data, e.d);
        end
      end else begin
        check("idle_command", DW'(command), '0);
        check("idle_write_data", write_data, '0);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [33:0] c, input logic [DW-1:0] d);
    host_if.in_valid      = 1'b1;
    host_if.in_command    = c;
    host_if.in_write_data = d;
    cycle();
    host_if.in_valid      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [33:0]   c;
    logic [DW-1:0] a5;
    host_if.in_valid      = 1'b0;
    host_if.in_command    = '0;
    host_if.in_write_data = '0;
    a5 = {16{8'hA5}};

    // reset state
    idle(3);
    check("rst_valid", DW'(valid), '0);
    check("rst_command", DW'(command), '0);
    check("rst_write_data", write_data, '0);
    check("rst_rd_outstanding", DW'(rd_outstanding), '0);
    check("rst_err", DW'(err_malformed), '0);
    rst_n = 1'b1;
    cycle();
    check("rst_in_ready", DW'(host_if.in_ready), DW'(1));

    // 1: single write, bank 0 ready
    ba_cmd_pm = 8'h01;
    push(mk_cmd(2'd0, 1'b0, 13'd5, 1'b1, 1'b0, 10'd0, 3'd0), a5);
    idle(3);

    // 2: fill while blocked, one rejected extra push, then drain in order
    ba_cmd_pm = 8'h00;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(mk_cmd(2'($urandom), 1'b0, 13'($urandom), 1'b1, 1'($urandom), 10'($urandom),
                  3'($urandom)), rnd_data());
    end
    idle(3);
    ba_cmd_pm = 8'hFF;
    idle(DEPTH + 2);

    // 3: read limit, release, issue and return in the same cycle
    for (int i = 0; i < 3; i++) begin
      push(mk_cmd(2'd1, 1'b1, 13'(i), 1'b1, 1'b0, 10'(i), 3'(i)), rnd_data());
    end
    idle(3);
    read_data_valid = 1'b1; cycle(); read_data_valid = 1'b0;
    idle(2);
    read_data_valid = 1'b1; cycle(); read_data_valid = 1'b0;
    push(mk_cmd(2'd2, 1'b1, 13'd9, 1'b1, 1'b1, 10'd9, 3'd4), rnd_data());
    read_data_valid = 1'b1; cycle();
    cycle();
    cycle(); read_data_valid = 1'b0;
    idle(2);

    // 4: malformed commands dropped, following good command issues
    c = mk_cmd(2'd0, 1'b0, 13'd7, 1'b1, 1'b0, 10'd3, 3'd1);
    c[30] = 1'b1;
    push(c, rnd_data());
    c = mk_cmd(2'd0, 1'b0, 13'd7, 1'b0, 1'b0, 10'd3, 3'd1);
    push(c, rnd_data());
    push(mk_cmd(2'd3, 1'b0, 13'd8, 1'b1, 1'b0, 10'd4, 3'd2), rnd_data());
    idle(3);

    // 5: blocked head stalls a ready command behind it
    ba_cmd_pm = 8'h01;
    push(mk_cmd(2'd0, 1'b0, 13'd1, 1'b1, 1'b0, 10'd1, 3'd1), rnd_data());
    push(mk_cmd(2'd0, 1'b0, 13'd2, 1'b1, 1'b0, 10'd2, 3'd0), rnd_data());
    idle(5);
    ba_cmd_pm = 8'hFF;
    idle(3);

    // 6: reset with commands queued and a read in flight
    push(mk_cmd(2'd0, 1'b1, 13'd3, 1'b1, 1'b0, 10'd3, 3'd2), rnd_data());
    ba_cmd_pm = 8'h00;
    for (int i = 0; i < 5; i++) begin
      push(mk_cmd(2'd1, 1'b0, 13'(i), 1'b1, 1'b0, 10'(i), 3'd3), rnd_data());
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", DW'(valid), '0);
    check("mid_rst_command", DW'(command), '0);
    check("mid_rst_write_data", write_data, '0);
    check("mid_rst_rd_outstanding", DW'(rd_outstanding), '0);
    check("mid_rst_in_ready", DW'(host_if.in_ready), DW'(1));
    cycle();
    rst_n = 1'b1;
    ba_cmd_pm = 8'hFF;
    idle(5);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      c = mk_cmd(2'($urandom), 1'($urandom), 13'($urandom), 1'b1, 1'($urandom), 10'($urandom),
                 3'($urandom));
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: c[14] = 1'b1;
          1: c[16] = 1'b1;
          2: c[30] = 1'b1;
          default: c[15] = 1'b0;
        endcase
      end
      host_if.in_valid      = 1'($urandom);
      host_if.in_command    = c;
      host_if.in_write_data = rnd_data();
      ba_cmd_pm             = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
      read_data_valid       = ($urandom_range(3) == 0);
      cycle();
    end

    // bounded drain
    host_if.in_valid = 1'b0;
    ba_cmd_pm        = 8'hFF;
    read_data_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (mq.size() == 0 && exp_q.size() == 0 && m_rd == 0) break;
      cycle();
    end
    read_data_valid = 1'b0;
    idle(2);
    check("drain_model_queue", DW'(mq.size()), '0);
    check("drain_scoreboard", DW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
